// File: rtl/timer_pkg.sv
// Shared types for the timer sequencer: FSM state encoding and default counter width.
package timer_pkg;

    localparam int CNT_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tseq_state_t;

endpackage

// File: rtl/timer_sequencer_if.sv
// Control/status bundle between software-side control, the compare/PWM output stage and
// the timer sequencer. master = driving side, slave = timer_sequencer.
interface timer_sequencer_if #(
    parameter int NUM_COMP = 3,
    parameter int CNT_W    = 8
) ();
    import timer_pkg::*;

    localparam int IDX_W = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;

    // No valid/ready pairs here: start/stop/oneshot are level-sampled every clk, cfg_we and
    // flag_clr are single-cycle strobes that are always accepted (implicit ready=1), and
    // done is a one-cycle pulse with no back-pressure.
    logic                           start;
    logic                           stop;
    logic                           oneshot;
    logic [CNT_W-1:0]               period;
    logic [CNT_W-1:0]               prescale;
    logic                           cfg_we;
    logic [IDX_W-1:0]               cfg_idx;
    logic [CNT_W-1:0]               cfg_data;
    logic [NUM_COMP-1:0]            match;
    logic [NUM_COMP-1:0]            flag_clr;
    logic [CNT_W-1:0]               counter_value;
    logic [NUM_COMP-1:0][CNT_W-1:0] match_value;
    logic                           en;
    logic [NUM_COMP-1:0]            flag;
    logic                           busy;
    logic                           done;
    tseq_state_t                    state_dbg;

    modport master (
        output start, stop, oneshot, period, prescale, cfg_we, cfg_idx, cfg_data,
               match, flag_clr,
        input  counter_value, match_value, en, flag, busy, done, state_dbg
    );

    modport slave (
        input  start, stop, oneshot, period, prescale, cfg_we, cfg_idx, cfg_data,
               match, flag_clr,
        output counter_value, match_value, en, flag, busy, done, state_dbg
    );

endinterface

// File: rtl/timer_prescaler.sv
// Clock prescaler: emits a tick every prescale+1 clocks while run_i is high.
// clr_i restarts the division so the first tick after a start lands a full interval later.
module timer_prescaler #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             run_i,
    input  logic [CNT_W-1:0] prescale_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] presc_cnt_q;
    logic [CNT_W-1:0] presc_cnt_d;
    logic             at_limit;

    assign at_limit = (presc_cnt_q == prescale_i);
    assign tick_o   = run_i && at_limit;

    always_comb begin
        presc_cnt_d = presc_cnt_q;
        if (clr_i) begin
            presc_cnt_d = '0;
        end else if (run_i) begin
            presc_cnt_d = at_limit ? '0 : presc_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_cnt_q <= '0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// Timer sequencer: run/stop/one-shot FSM, up-counter, match registers and sticky match flags.
// Optional TIMER_SHADOW_EN: match writes go to shadows copied to the active set at start/wrap.
module timer_sequencer #(
    parameter int NUM_COMP = 3,
    parameter int CNT_W    = timer_pkg::CNT_W
) (
    input logic               clk,
    input logic               rst,
    timer_sequencer_if.slave  bus
);
    import timer_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    tseq_state_t                    state_q, state_d;
    logic [CNT_W-1:0]               counter_q, counter_d;
    logic                           oneshot_q, oneshot_d;
    logic                           done_q, done_d;
    logic [NUM_COMP-1:0]            flag_q, flag_d;
    logic [NUM_COMP-1:0]            match_prev_q;
    logic [NUM_COMP-1:0][CNT_W-1:0] active_q, active_d;
    logic                           launch;
    logic                           wrap_tick;
    logic                           tick;
    logic                           running;
    logic                           cfg_hit;

    assign running = (state_q == RUN);
    assign cfg_hit = bus.cfg_we && (int'(bus.cfg_idx) < NUM_COMP);

    timer_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (launch),
        .run_i      (running),
        .prescale_i (bus.prescale),
        .tick_o     (tick)
    );

    // stop outranks start and the terminal-count event; the counter is left where it was.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        oneshot_d = oneshot_q;
        done_d    = 1'b0;
        launch    = 1'b0;
        wrap_tick = 1'b0;
        if (bus.stop) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d   = RUN;
                        counter_d = '0;
                        oneshot_d = bus.oneshot;
                        launch    = 1'b1;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (counter_q == bus.period) begin
                            if (oneshot_q) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end else begin
                                counter_d = '0;
                                wrap_tick = 1'b1;
                            end
                        end else begin
                            // Counter above a freshly lowered period rolls over naturally.
                            counter_d = counter_q + 1'b1;
                            wrap_tick = (counter_q == CNT_MAX);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        flag_d = (flag_q & ~bus.flag_clr) | (bus.match & ~match_prev_q & {NUM_COMP{running}});
    end

`ifdef TIMER_SHADOW_EN
    logic [NUM_COMP-1:0][CNT_W-1:0] shadow_q, shadow_d;

    // Copy reads the pre-write shadow, so a write on the wrap cycle waits for the next wrap.
    always_comb begin
        shadow_d = shadow_q;
        if (cfg_hit) begin
            shadow_d[bus.cfg_idx] = bus.cfg_data;
        end
        active_d = active_q;
        if (launch || wrap_tick) begin
            active_d = shadow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    always_comb begin
        active_d = active_q;
        if (cfg_hit) begin
            active_d[bus.cfg_idx] = bus.cfg_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            counter_q    <= '0;
            oneshot_q    <= 1'b0;
            done_q       <= 1'b0;
            flag_q       <= '0;
            match_prev_q <= '0;
            active_q     <= '0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            oneshot_q    <= oneshot_d;
            done_q       <= done_d;
            flag_q       <= flag_d;
            match_prev_q <= bus.match;
            active_q     <= active_d;
        end
    end

    assign bus.counter_value = counter_q;
    assign bus.match_value   = active_q;
    assign bus.en            = running;
    assign bus.flag          = flag_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = done_q;
    assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer: drivers queue expected observations tagged with the
// cycle they must appear in; a negedge monitor pops and compares them.
module tb_timer_sequencer;
    import timer_pkg::*;

    localparam int NUM_COMP = 3;
    localparam int CNT_W    = 8;

    localparam logic [7:0] ID_CNT   = 8'd0;
    localparam logic [7:0] ID_EN    = 8'd1;
    localparam logic [7:0] ID_BUSY  = 8'd2;
    localparam logic [7:0] ID_DONE  = 8'd3;
    localparam logic [7:0] ID_FLAG  = 8'd4;
    localparam logic [7:0] ID_MV0   = 8'd5;
    localparam logic [7:0] ID_MV1   = 8'd6;
    localparam logic [7:0] ID_MV2   = 8'd7;
    localparam logic [7:0] ID_STATE = 8'd8;

`ifdef TIMER_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    timer_sequencer_if #(.NUM_COMP(NUM_COMP), .CNT_W(CNT_W)) bus ();

    timer_sequencer #(.NUM_COMP(NUM_COMP), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: {cycle[15:0], id[7:0], value[15:0]}
    logic [39:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          flush  = 1'b0;
    logic [39:0] mon_e;
    logic [15:0] mon_act;

    function automatic string id_name(input logic [7:0] id);
        case (id)
            ID_CNT:   return "counter_value";
            ID_EN:    return "en";
            ID_BUSY:  return "busy";
            ID_DONE:  return "done";
            ID_FLAG:  return "flag";
            ID_MV0:   return "match_value0";
            ID_MV1:   return "match_value1";
            ID_MV2:   return "match_value2";
            ID_STATE: return "state";
            default:  return "unknown";
        endcase
    endfunction

    function automatic logic [15:0] actual_of(input logic [7:0] id);
        case (id)
            ID_CNT:   return 16'(bus.counter_value);
            ID_EN:    return 16'(bus.en);
            ID_BUSY:  return 16'(bus.busy);
            ID_DONE:  return 16'(bus.done);
            ID_FLAG:  return 16'(bus.flag);
            ID_MV0:   return 16'(bus.match_value[0]);
            ID_MV1:   return 16'(bus.match_value[1]);
            ID_MV2:   return 16'(bus.match_value[2]);
            ID_STATE: return 16'(bus.state_dbg);
            default:  return 16'hffff;
        endcase
    endfunction

    always @(negedge clk) begin
        while (exp_q.size() != 0 && (flush || exp_q[0][39:24] <= cyc[15:0])) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (mon_e[39:24] != cyc[15:0]) begin
                errors++;
                $display("FAIL %s: check for cycle %0d not reached (now cycle %0d), expected %0d",
                         id_name(mon_e[23:16]), mon_e[39:24], cyc, mon_e[15:0]);
            end else begin
                mon_act = actual_of(mon_e[23:16]);
                if (mon_act !== mon_e[15:0]) begin
                    errors++;
                    $display("FAIL %s @cycle %0d: got %0d expected %0d",
                             id_name(mon_e[23:16]), cyc, mon_act, mon_e[15:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic expect_at(input int d, input logic [7:0] id, input logic [15:0] val);
        exp_q.push_back({16'(cyc + 32'(d)), id, val});
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.oneshot  = 1'b0;
        bus.period   = '0;
        bus.prescale = '0;
        bus.cfg_we   = 1'b0;
        bus.cfg_idx  = '0;
        bus.cfg_data = '0;
        bus.match    = '0;
        bus.flag_clr = '0;

        // reset state
        wait_neg(3);
        rst = 1'b1;
        expect_at(1, ID_CNT, 0);
        expect_at(1, ID_EN, 0);
        expect_at(1, ID_BUSY, 0);
        expect_at(1, ID_DONE, 0);
        expect_at(1, ID_FLAG, 0);
        expect_at(1, ID_MV0, 0);
        expect_at(1, ID_MV1, 0);
        expect_at(1, ID_MV2, 0);
        expect_at(1, ID_STATE, 16'(IDLE));
        wait_neg(1);

        // periodic, prescale 0, period 4, then stop holds the count
        bus.prescale = 8'd0;
        bus.period   = 8'd4;
        bus.oneshot  = 1'b0;
        bus.start    = 1'b1;
        expect_at(1, ID_CNT, 0);
        expect_at(1, ID_EN, 1);
        expect_at(1, ID_STATE, 16'(RUN));
        expect_at(2, ID_CNT, 1);
        expect_at(3, ID_CNT, 2);
        expect_at(4, ID_CNT, 3);
        expect_at(5, ID_CNT, 4);
        expect_at(5, ID_DONE, 0);
        expect_at(6, ID_CNT, 0);
        expect_at(7, ID_CNT, 1);
        expect_at(8, ID_CNT, 1);
        expect_at(8, ID_EN, 0);
        expect_at(8, ID_BUSY, 0);
        wait_neg(1);
        bus.start = 1'b0;
        wait_neg(6);
        bus.stop = 1'b1;
        wait_neg(1);
        bus.stop = 1'b0;

        // stop and start together while running
        bus.start = 1'b1;
        expect_at(1, ID_EN, 1);
        expect_at(3, ID_CNT, 2);
        expect_at(4, ID_CNT, 2);
        expect_at(4, ID_EN, 0);
        expect_at(4, ID_BUSY, 0);
        expect_at(4, ID_STATE, 16'(IDLE));
        wait_neg(1);
        bus.start = 1'b0;
        wait_neg(2);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        wait_neg(1);
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        // one-shot, prescale 1, period 3
        bus.prescale = 8'd1;
        bus.period   = 8'd3;
        bus.oneshot  = 1'b1;
        bus.start    = 1'b1;
        expect_at(1, ID_CNT, 0);
        expect_at(2, ID_CNT, 0);
        expect_at(3, ID_CNT, 1);
        expect_at(4, ID_CNT, 1);
        expect_at(5, ID_CNT, 2);
        expect_at(6, ID_CNT, 2);
        expect_at(7, ID_CNT, 3);
        expect_at(8, ID_CNT, 3);
        expect_at(8, ID_EN, 1);
        expect_at(8, ID_DONE, 0);
        expect_at(9, ID_CNT, 3);
        expect_at(9, ID_DONE, 1);
        expect_at(9, ID_EN, 0);
        expect_at(9, ID_STATE, 16'(DONE));
        expect_at(10, ID_CNT, 3);
        expect_at(10, ID_DONE, 0);
        expect_at(10, ID_BUSY, 1);
        wait_neg(1);
        bus.start   = 1'b0;
        bus.oneshot = 1'b0;
        wait_neg(9);
        bus.stop = 1'b1;
        expect_at(1, ID_BUSY, 0);
        expect_at(1, ID_STATE, 16'(IDLE));
        wait_neg(1);
        bus.stop = 1'b0;

        // period 0 one-shot completes on the first tick; restart from DONE
        bus.prescale = 8'd0;
        bus.period   = 8'd0;
        bus.oneshot  = 1'b1;
        bus.start    = 1'b1;
        expect_at(1, ID_CNT, 0);
        expect_at(1, ID_STATE, 16'(RUN));
        expect_at(2, ID_CNT, 0);
        expect_at(2, ID_DONE, 1);
        expect_at(2, ID_STATE, 16'(DONE));
        expect_at(3, ID_DONE, 0);
        expect_at(3, ID_STATE, 16'(RUN));
        expect_at(4, ID_CNT, 0);
        expect_at(4, ID_STATE, 16'(IDLE));
        wait_neg(1);
        bus.start   = 1'b0;
        bus.oneshot = 1'b0;
        wait_neg(1);
        bus.start = 1'b1;
        wait_neg(1);
        bus.start = 1'b0;
        bus.stop  = 1'b1;
        wait_neg(1);
        bus.stop = 1'b0;

        // match register writes mid-run, including an out-of-range index
        bus.period = 8'd4;
        bus.start  = 1'b1;
        expect_at(2, ID_MV0, 0);
        expect_at(3, ID_MV0, SHADOW ? 16'd0 : 16'd2);
        expect_at(4, ID_MV2, 0);
        expect_at(5, ID_MV0, SHADOW ? 16'd0 : 16'd2);
        expect_at(5, ID_MV1, SHADOW ? 16'd0 : 16'd5);
        expect_at(6, ID_CNT, 0);
        expect_at(6, ID_MV0, 2);
        expect_at(6, ID_MV1, 5);
        expect_at(7, ID_MV2, 0);
        wait_neg(1);
        bus.start = 1'b0;
        wait_neg(1);
        bus.cfg_we   = 1'b1;
        bus.cfg_idx  = 2'd0;
        bus.cfg_data = 8'd2;
        wait_neg(1);
        bus.cfg_idx  = 2'd3;
        bus.cfg_data = 8'd7;
        wait_neg(1);
        bus.cfg_idx  = 2'd1;
        bus.cfg_data = 8'd5;
        wait_neg(1);
        bus.cfg_we = 1'b0;
        wait_neg(2);
        bus.stop = 1'b1;
        wait_neg(1);
        bus.stop = 1'b0;

        // flags: set wins over clear, clear alone, no set while en=0, sticky across stop
        bus.start = 1'b1;
        expect_at(1, ID_FLAG, 0);
        expect_at(2, ID_FLAG, 3'b010);
        expect_at(3, ID_FLAG, 3'b000);
        expect_at(4, ID_FLAG, 3'b001);
        expect_at(6, ID_FLAG, 3'b001);
        wait_neg(1);
        bus.start    = 1'b0;
        bus.match    = 3'b010;
        bus.flag_clr = 3'b010;
        wait_neg(1);
        wait_neg(1);
        bus.flag_clr = 3'b000;
        bus.match    = 3'b001;
        wait_neg(1);
        bus.match = 3'b000;
        bus.stop  = 1'b1;
        wait_neg(1);
        bus.stop  = 1'b0;
        bus.match = 3'b100;
        wait_neg(1);
        bus.match = 3'b000;

        // reset asserted mid-run
        bus.start = 1'b1;
        expect_at(3, ID_CNT, 2);
        expect_at(3, ID_FLAG, 3'b001);
        expect_at(4, ID_CNT, 0);
        expect_at(4, ID_EN, 0);
        expect_at(4, ID_BUSY, 0);
        expect_at(4, ID_FLAG, 0);
        expect_at(4, ID_MV0, 0);
        expect_at(4, ID_MV1, 0);
        expect_at(4, ID_STATE, 16'(IDLE));
        wait_neg(1);
        bus.start = 1'b0;
        wait_neg(2);
        rst = 1'b0;
        wait_neg(1);
        rst = 1'b1;

        // drain; anything still queued is reported as a missed check
        wait_neg(3);
        flush = 1'b1;
        wait_neg(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
